logic_gates_3: RTL and testbench



---
 rtl/logic_gates_pkg.sv | 17 +
 rtl/sat_counter.sv | 31 +++
 rtl/logic_gates_3.sv | 110 +++++++++++
 tb/tb_logic_gates_3.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/logic_gates_pkg.sv
// rtl/logic_gates_pkg.sv - shared defaults and gate result layout for logic_gates_3
package logic_gates_pkg;

  localparam int unsigned DEFAULT_WIDTH = 1;
  localparam int unsigned DEFAULT_CNT_W = 8;

  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] and_v;
    logic [DEFAULT_WIDTH-1:0] or_v;
    logic [DEFAULT_WIDTH-1:0] not_v;
    logic [DEFAULT_WIDTH-1:0] nand_v;
    logic [DEFAULT_WIDTH-1:0] nor_v;
    logic [DEFAULT_WIDTH-1:0] xor_v;
    logic [DEFAULT_WIDTH-1:0] xnor_v;
  } gate_vec_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous active-high clear
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iInc,
  output logic [CNT_W-1:0] oCnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (iInc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign oCnt = cnt_q;

endmodule

// File: rtl/logic_gates_3.sv
// rtl/logic_gates_3.sv - bitwise gate unit with change / AND-high activity counters
// LOGIC_GATES_3_REG_OUT_EN: registers all seven gate outputs (1-cycle latency).
module logic_gates_3
  import logic_gates_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic [WIDTH-1:0] oAnd,
  output logic [WIDTH-1:0] oOr,
  output logic [WIDTH-1:0] oNot,
  output logic [WIDTH-1:0] oNand,
  output logic [WIDTH-1:0] oNor,
  output logic [WIDTH-1:0] oXor,
  output logic [WIDTH-1:0] oXnor,
  output logic [CNT_W-1:0] oChgCnt,
  output logic [CNT_W-1:0] oAndHiCnt
);

  // Same field order as gate_vec_t, sized by this instance's WIDTH.
  typedef struct packed {
    logic [WIDTH-1:0] and_v;
    logic [WIDTH-1:0] or_v;
    logic [WIDTH-1:0] not_v;
    logic [WIDTH-1:0] nand_v;
    logic [WIDTH-1:0] nor_v;
    logic [WIDTH-1:0] xor_v;
    logic [WIDTH-1:0] xnor_v;
  } gates_t;

  gates_t           gates_d;
  gates_t           gates_o;
  logic [WIDTH-1:0] prev_a_q;
  logic [WIDTH-1:0] prev_b_q;
  logic             chg;
  logic             and_hi;

  always_comb begin
    gates_d.and_v  = iA & iB;
    gates_d.or_v   = iA | iB;
    gates_d.not_v  = ~iA;
    gates_d.nand_v = ~(iA & iB);
    gates_d.nor_v  = ~(iA | iB);
    gates_d.xor_v  = iA ^ iB;
    gates_d.xnor_v = ~(iA ^ iB);
  end

`ifdef LOGIC_GATES_3_REG_OUT_EN
  gates_t gates_q;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      gates_q.and_v  <= '0;
      gates_q.or_v   <= '0;
      gates_q.not_v  <= '1;
      gates_q.nand_v <= '1;
      gates_q.nor_v  <= '0;
      gates_q.xor_v  <= '0;
      gates_q.xnor_v <= '1;
    end else begin
      gates_q <= gates_d;
    end
  end

  assign gates_o = gates_q;
`else
  assign gates_o = gates_d;
`endif

  assign oAnd  = gates_o.and_v;
  assign oOr   = gates_o.or_v;
  assign oNot  = gates_o.not_v;
  assign oNand = gates_o.nand_v;
  assign oNor  = gates_o.nor_v;
  assign oXor  = gates_o.xor_v;
  assign oXnor = gates_o.xnor_v;

  // Counters always observe the raw inputs, independent of the output stage.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      prev_a_q <= '0;
      prev_b_q <= '0;
    end else begin
      prev_a_q <= iA;
      prev_b_q <= iB;
    end
  end

  assign chg    = ({iA, iB} != {prev_a_q, prev_b_q});
  assign and_hi = |(iA & iB);

  sat_counter #(.CNT_W(CNT_W)) u_chg_cnt (
    .iClk (iClk),
    .iRst (iRst),
    .iInc (chg),
    .oCnt (oChgCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_and_hi_cnt (
    .iClk (iClk),
    .iRst (iRst),
    .iInc (and_hi),
    .oCnt (oAndHiCnt)
  );

endmodule

// File: tb/tb_logic_gates_3.sv
// tb/tb_logic_gates_3.sv - directed vector bench for logic_gates_3 (8-bit and 3-bit counter instances)
module tb_logic_gates_3;

  logic       clk;
  logic       rst;
  logic       a;
  logic       b;
  logic       o_and, o_or, o_not, o_nand, o_nor, o_xor, o_xnor;
  logic [7:0] chg_cnt, andhi_cnt;
  logic       s_and, s_or, s_not, s_nand, s_nor, s_xor, s_xnor;
  logic [2:0] s_chg_cnt, s_andhi_cnt;

  int total;
  int bad;

  typedef struct {
    logic a;
    logic b;
    logic e_and;
    logic e_or;
    logic e_not;
    logic e_nand;
    logic e_nor;
    logic e_xor;
    logic e_xnor;
  } vec_t;

  vec_t vecs [7];

  logic_gates_3 #(.WIDTH(1), .CNT_W(8)) dut (
    .iClk(clk), .iRst(rst), .iA(a), .iB(b),
    .oAnd(o_and), .oOr(o_or), .oNot(o_not), .oNand(o_nand),
    .oNor(o_nor), .oXor(o_xor), .oXnor(o_xnor),
    .oChgCnt(chg_cnt), .oAndHiCnt(andhi_cnt)
  );

  logic_gates_3 #(.WIDTH(1), .CNT_W(3)) dut_s (
    .iClk(clk), .iRst(rst), .iA(a), .iB(b),
    .oAnd(s_and), .oOr(s_or), .oNot(s_not), .oNand(s_nand),
    .oNor(s_nor), .oXor(s_xor), .oXnor(s_xnor),
    .oChgCnt(s_chg_cnt), .oAndHiCnt(s_andhi_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{a:0, b:0, e_and:0, e_or:0, e_not:1, e_nand:1, e_nor:1, e_xor:0, e_xnor:1};
    vecs[1] = '{a:1, b:0, e_and:0, e_or:1, e_not:0, e_nand:1, e_nor:0, e_xor:1, e_xnor:0};
    vecs[2] = '{a:0, b:1, e_and:0, e_or:1, e_not:1, e_nand:1, e_nor:0, e_xor:1, e_xnor:0};
    vecs[3] = '{a:1, b:1, e_and:1, e_or:1, e_not:0, e_nand:0, e_nor:0, e_xor:0, e_xnor:1};
    vecs[4] = '{a:0, b:0, e_and:0, e_or:0, e_not:1, e_nand:1, e_nor:1, e_xor:0, e_xnor:1};
    vecs[5] = '{a:1, b:1, e_and:1, e_or:1, e_not:0, e_nand:0, e_nor:0, e_xor:0, e_xnor:1};
    vecs[6] = '{a:1, b:0, e_and:0, e_or:1, e_not:0, e_nand:1, e_nor:0, e_xor:1, e_xnor:0};

    rst = 1'b1;
    a   = 1'b0;
    b   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_chg", int'(chg_cnt), 0);
    check("rst_andhi", int'(andhi_cnt), 0);
    check("rst_s_chg", int'(s_chg_cnt), 0);
    check("rst_not", int'(o_not), 1);
    check("rst_and", int'(o_and), 0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      a = vecs[i].a;
      b = vecs[i].b;
`ifdef LOGIC_GATES_3_REG_OUT_EN
      @(posedge clk);
`endif
      #1;
      check($sformatf("v%0d_and", i),  int'(o_and),  int'(vecs[i].e_and));
      check($sformatf("v%0d_or", i),   int'(o_or),   int'(vecs[i].e_or));
      check($sformatf("v%0d_not", i),  int'(o_not),  int'(vecs[i].e_not));
      check($sformatf("v%0d_nand", i), int'(o_nand), int'(vecs[i].e_nand));
      check($sformatf("v%0d_nor", i),  int'(o_nor),  int'(vecs[i].e_nor));
      check($sformatf("v%0d_xor", i),  int'(o_xor),  int'(vecs[i].e_xor));
      check($sformatf("v%0d_xnor", i), int'(o_xnor), int'(vecs[i].e_xnor));
    end

    // Hold A1B1 for five edges after a reset: one change (from cleared sample), five AND-high.
    @(negedge clk);
    rst = 1'b1;
    a   = 1'b0;
    b   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    a   = 1'b1;
    b   = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("hold_andhi", int'(andhi_cnt), 5);
    check("hold_chg", int'(chg_cnt), 1);

    // Toggle iA ten times: 3-bit counter pins at 7, 8-bit counter reaches 10.
    @(negedge clk);
    rst = 1'b1;
    a   = 1'b0;
    b   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a = ~a;
      @(negedge clk);
      if (i == 6) check("sat_reach7", int'(s_chg_cnt), 7);
    end
    check("sat_hold7", int'(s_chg_cnt), 7);
    check("sat_wide10", int'(chg_cnt), 10);
    check("sat_andhi0", int'(s_andhi_cnt), 0);

    // Reset mid-count while the input is still changing, then resume from the cleared sample.
    rst = 1'b1;
    a   = ~a;
    @(posedge clk);
    #1;
    check("midrst_chg", int'(chg_cnt), 0);
    check("midrst_s_chg", int'(s_chg_cnt), 0);
    check("midrst_andhi", int'(andhi_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    a   = 1'b1;
    b   = 1'b1;
    @(posedge clk);
    #1;
    check("resume_chg", int'(chg_cnt), 1);
    check("resume_andhi", int'(andhi_cnt), 1);

`ifdef LOGIC_GATES_3_REG_OUT_EN
    @(negedge clk);
    rst = 1'b1;
    a   = 1'b1;
    b   = 1'b1;
    @(posedge clk);
    #1;
    check("reg_rst_not", int'(o_not), 1);
    check("reg_rst_and", int'(o_and), 0);
    check("reg_rst_nand", int'(o_nand), 1);
    @(negedge clk);
    rst = 1'b0;
    a   = 1'b0;
    b   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a = 1'b1;
    b = 1'b1;
    #1;
    check("reg_lat_before", int'(o_and), 0);
    @(posedge clk);
    #1;
    check("reg_lat_after", int'(o_and), 1);
`else
    @(negedge clk);
    rst = 1'b1;
    a   = 1'b1;
    b   = 1'b1;
    #1;
    check("comb_rst_ign_and", int'(o_and), 1);
    check("comb_rst_ign_not", int'(o_not), 0);
    a = 1'b0;
    #1;
    check("comb_zero_lat_and", int'(o_and), 0);
    check("comb_zero_lat_xor", int'(o_xor), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
